// File: rtl/pipe_pkg.sv
// Shared constants and state encoding for the valid/ready pipeline stage.
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_stage_hs_sat_counter.sv
// Saturating up-counter; counts cycles with inc high and holds at all-ones.
module sat_counter #(
  parameter int CW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          inc,
  output logic [CW-1:0] count
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CW{1'b1}})) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline register with a one-entry skid buffer, flush-to-NOP
// and a saturating downstream stall counter.
//
// state | meaning
// EMPTY | nothing held, outputs present a NOP, ready
// FULL  | main holds the presented beat, skid free, ready
// SKID  | main presented, skid holds the next beat, not ready
module pipe_stage_hs
  import pipe_pkg::*;
#(
  parameter int PW = 96,
  parameter int CW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [31:0]   instr_i,
  input  logic [PW-1:0] payload_i,
  input  logic          flush_i,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [31:0]   instr_o,
  output logic [PW-1:0] payload_o,
  output logic [CW-1:0] stall_cnt_o
);

  pipe_state_e   state_q, state_d;
  logic [31:0]   main_instr_q, main_instr_d;
  logic [PW-1:0] main_payload_q, main_payload_d;
  logic [31:0]   skid_instr_q, skid_instr_d;
  logic [PW-1:0] skid_payload_q, skid_payload_d;

  logic accept;
  logic send;

  // Both handshake outputs decode from registered state only, so ready_i
  // never reaches ready_o combinationally.
  assign valid_o = (state_q != EMPTY);
  assign ready_o = (state_q != SKID);
  assign accept  = valid_i && ready_o;
  assign send    = valid_o && ready_i;

  always_comb begin
    state_d        = state_q;
    main_instr_d   = main_instr_q;
    main_payload_d = main_payload_q;
    skid_instr_d   = skid_instr_q;
    skid_payload_d = skid_payload_q;

    if (flush_i) begin
      state_d        = EMPTY;
      main_instr_d   = NOP_INSTR;
      main_payload_d = '0;
      skid_instr_d   = NOP_INSTR;
      skid_payload_d = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d        = FULL;
            main_instr_d   = instr_i;
            main_payload_d = payload_i;
          end
        end
        FULL: begin
          if (send && accept) begin
            main_instr_d   = instr_i;
            main_payload_d = payload_i;
          end else if (send) begin
            state_d        = EMPTY;
            main_instr_d   = NOP_INSTR;
            main_payload_d = '0;
          end else if (accept) begin
            state_d        = SKID;
            skid_instr_d   = instr_i;
            skid_payload_d = payload_i;
          end
        end
        SKID: begin
          if (send) begin
            state_d        = FULL;
            main_instr_d   = skid_instr_q;
            main_payload_d = skid_payload_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= EMPTY;
      main_instr_q   <= NOP_INSTR;
      main_payload_q <= '0;
      skid_instr_q   <= NOP_INSTR;
      skid_payload_q <= '0;
    end else begin
      state_q        <= state_d;
      main_instr_q   <= main_instr_d;
      main_payload_q <= main_payload_d;
      skid_instr_q   <= skid_instr_d;
      skid_payload_q <= skid_payload_d;
    end
  end

  assign instr_o   = main_instr_q;
  assign payload_o = main_payload_q;

  // Flush does not touch the counter; only reset clears it.
  sat_counter #(
    .CW(CW)
  ) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (valid_o && !ready_i),
    .count (stall_cnt_o)
  );

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Self-checking bench for pipe_stage_hs: scoreboard of accepted beats plus
// per-scenario directed checks.
module tb_pipe_stage_hs;

  localparam int PW = 96;
  localparam int CW = 4;
  localparam logic [31:0]   NOP  = 32'h00000013;
  localparam logic [CW-1:0] SMAX = {CW{1'b1}};

  typedef struct packed {
    logic [31:0]   instr;
    logic [PW-1:0] payload;
  } beat_t;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [31:0]   instr_i = '0;
  logic [PW-1:0] payload_i = '0;
  logic          flush_i = 1'b0;
  logic          valid_o;
  logic          ready_i = 1'b0;
  logic [31:0]   instr_o;
  logic [PW-1:0] payload_o;
  logic [CW-1:0] stall_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  beat_t         sb_q[$];
  logic [CW-1:0] stall_model = '0;

  pipe_stage_hs #(.PW(PW), .CW(CW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .instr_i     (instr_i),
    .payload_i   (payload_i),
    .flush_i     (flush_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .instr_o     (instr_o),
    .payload_o   (payload_o),
    .stall_cnt_o (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [PW-1:0] rnd_payload();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  // Monitor: inputs change #1 after posedge, so the negedge sees exactly the
  // values that the next posedge will act on.
  always @(negedge clk_i) begin
    logic  m_send, m_accept;
    beat_t exp_b;
    if (rst_i) begin
      sb_q.delete();
      stall_model = '0;
    end else begin
      m_send   = (sb_q.size() != 0) && ready_i;
      m_accept = valid_i && (sb_q.size() < 2);
      n_vec++;
      if (valid_o !== (sb_q.size() != 0)) begin
        n_err++;
        $display("FAIL mon_valid got %b exp %b", valid_o, sb_q.size() != 0);
      end
      n_vec++;
      if (ready_o !== (sb_q.size() < 2)) begin
        n_err++;
        $display("FAIL mon_ready got %b exp %b", ready_o, sb_q.size() < 2);
      end
      n_vec++;
      if (stall_cnt_o !== stall_model) begin
        n_err++;
        $display("FAIL mon_stall got %0d exp %0d", stall_cnt_o, stall_model);
      end
      if (sb_q.size() == 0) begin
        n_vec++;
        if (instr_o !== NOP || payload_o !== '0) begin
          n_err++;
          $display("FAIL mon_idle_nop got %h/%h exp %h/0", instr_o, payload_o, NOP);
        end
      end
      if (m_send) begin
        exp_b = sb_q.pop_front();
        n_vec++;
        if (instr_o !== exp_b.instr || payload_o !== exp_b.payload) begin
          n_err++;
          $display("FAIL mon_beat got %h/%h exp %h/%h", instr_o, payload_o,
                   exp_b.instr, exp_b.payload);
        end
      end
      if (sb_q.size() != 0 && !ready_i && stall_model != SMAX) stall_model++;
      if (flush_i) sb_q.delete();
      else if (m_accept) sb_q.push_back('{instr: instr_i, payload: payload_i});
    end
  end

  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    valid_i = 1'b0;
    flush_i = 1'b0;
    instr_i = '0;
    payload_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    ready_i = 1'b0;
    rst_i = 1'b1;
    cycle();
    cycle();
    rst_i = 1'b0;
    cycle();
  endtask

  // Fill main and skid with two beats while downstream stalls.
  task automatic fill_skid(input logic [31:0] a, input logic [31:0] b);
    ready_i = 1'b0;
    valid_i = 1'b1; instr_i = a; payload_i = rnd_payload();
    cycle();
    instr_i = b; payload_i = rnd_payload();
    cycle();
    valid_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    fill_skid(32'hA, 32'hB);
    n_vec++;
    if (ready_o !== 1'b0 || valid_o !== 1'b1) begin
      n_err++;
      $display("FAIL reset_pre_skid got rdy=%b vld=%b exp 0/1", ready_o, valid_o);
    end
    #2 rst_i = 1'b1;
    #1;
    n_vec++;
    if (valid_o !== 1'b0 || instr_o !== NOP || payload_o !== '0 ||
        ready_o !== 1'b1 || stall_cnt_o !== '0) begin
      n_err++;
      $display("FAIL reset_async got v=%b i=%h p=%h r=%b s=%0d exp 0/%h/0/1/0",
               valid_o, instr_o, payload_o, ready_o, stall_cnt_o, NOP);
    end
    cycle();
    rst_i = 1'b0;
    cycle();
  endtask

  task automatic test_streaming();
    do_reset();
    ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      n_vec++;
      if (ready_o !== 1'b1) begin
        n_err++;
        $display("FAIL stream_ready beat %0d got %b exp 1", i, ready_o);
      end
      valid_i = 1'b1; instr_i = 32'(i); payload_i = rnd_payload();
      cycle();
      n_vec++;
      if (valid_o !== 1'b1 || instr_o !== 32'(i)) begin
        n_err++;
        $display("FAIL stream_latency got v=%b i=%h exp 1/%h", valid_o, instr_o, i);
      end
    end
    idle_inputs();
    cycle();
    cycle();
  endtask

  task automatic test_back_pressure();
    int waited;
    do_reset();
    fill_skid(32'hA, 32'hB);
    valid_i = 1'b1; instr_i = 32'hC; payload_i = rnd_payload();
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (ready_o !== 1'b0 || instr_o !== 32'hA) begin
        n_err++;
        $display("FAIL bp_hold got r=%b i=%h exp 0/a", ready_o, instr_o);
      end
      cycle();
    end
    n_vec++;
    if (stall_cnt_o !== CW'(4)) begin
      n_err++;
      $display("FAIL bp_stall_cnt got %0d exp 4", stall_cnt_o);
    end
    ready_i = 1'b1;
    waited = 0;
    while (ready_o !== 1'b1 && waited < 10) begin
      cycle();
      waited++;
    end
    n_vec++;
    if (waited != 1) begin
      n_err++;
      $display("FAIL bp_ready_return got %0d cycles exp 1", waited);
    end
    cycle();
    valid_i = 1'b0;
    for (int k = 0; k < 3; k++) cycle();
    n_vec++;
    if (valid_o !== 1'b0 || stall_cnt_o !== CW'(4)) begin
      n_err++;
      $display("FAIL bp_drained got v=%b s=%0d exp 0/4", valid_o, stall_cnt_o);
    end
  endtask

  task automatic test_flush();
    do_reset();
    fill_skid(32'h11, 32'h22);
    valid_i = 1'b1; instr_i = 32'hD; payload_i = rnd_payload();
    flush_i = 1'b1;
    cycle();
    idle_inputs();
    n_vec++;
    if (valid_o !== 1'b0 || instr_o !== NOP || payload_o !== '0 || ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL flush_skid got v=%b i=%h p=%h r=%b exp 0/%h/0/1",
               valid_o, instr_o, payload_o, ready_o, NOP);
    end
    ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      n_vec++;
      if (valid_o !== 1'b0 || instr_o === 32'hD) begin
        n_err++;
        $display("FAIL flush_no_d got v=%b i=%h exp 0/%h", valid_o, instr_o, NOP);
      end
    end
    // Flush coinciding with a send: the presented beat still completes.
    valid_i = 1'b1; instr_i = 32'h33; payload_i = rnd_payload();
    cycle();
    instr_i = 32'h44; payload_i = rnd_payload(); flush_i = 1'b1;
    cycle();
    idle_inputs();
    n_vec++;
    if (valid_o !== 1'b0 || instr_o !== NOP) begin
      n_err++;
      $display("FAIL flush_send got v=%b i=%h exp 0/%h", valid_o, instr_o, NOP);
    end
    cycle();
  endtask

  task automatic test_idle_after_drain();
    do_reset();
    ready_i = 1'b1;
    valid_i = 1'b1; instr_i = 32'h00500093; payload_i = rnd_payload();
    cycle();
    idle_inputs();
    n_vec++;
    if (valid_o !== 1'b1 || instr_o !== 32'h00500093) begin
      n_err++;
      $display("FAIL drain_present got v=%b i=%h exp 1/00500093", valid_o, instr_o);
    end
    cycle();
    n_vec++;
    if (valid_o !== 1'b0 || instr_o !== NOP || payload_o !== '0) begin
      n_err++;
      $display("FAIL drain_idle got v=%b i=%h p=%h exp 0/%h/0",
               valid_o, instr_o, payload_o, NOP);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    ready_i = 1'b0;
    valid_i = 1'b1; instr_i = 32'h55; payload_i = rnd_payload();
    cycle();
    idle_inputs();
    for (int k = 0; k < 20; k++) cycle();
    n_vec++;
    if (stall_cnt_o !== SMAX) begin
      n_err++;
      $display("FAIL sat_cap got %0d exp %0d", stall_cnt_o, SMAX);
    end
    flush_i = 1'b1;
    cycle();
    flush_i = 1'b0;
    cycle();
    n_vec++;
    if (stall_cnt_o !== SMAX || valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL sat_after_flush got s=%0d v=%b exp %0d/0", stall_cnt_o, valid_o, SMAX);
    end
  endtask

  task automatic test_back_to_back_random();
    do_reset();
    for (int k = 0; k < 200; k++) begin
      ready_i = ($urandom_range(0, 3) != 0);
      if (!valid_i || ready_o) begin
        valid_i = ($urandom_range(0, 3) != 0);
        instr_i = $urandom();
        payload_i = rnd_payload();
      end
      flush_i = ($urandom_range(0, 31) == 0);
      cycle();
    end
    idle_inputs();
    ready_i = 1'b1;
    for (int k = 0; k < 4; k++) cycle();
    n_vec++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL random_drain got v=%b r=%b exp 0/1", valid_o, ready_o);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_idle_after_drain();
    test_saturation();
    test_back_to_back_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
